// File: rtl/key_extractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : key_extractor                                                    |
// | Purpose : Per-stage PHV key extractor feeding a ready-less lookup engine.  |
// |           Optional key masking RAM enabled by KEY_EXTRACTOR_MASK_EN.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module key_extractor #(
  parameter int PHV_LEN = 1024,
  parameter int KEY_LEN = 192,
  parameter int CFG_W   = 39,
  parameter int MIN_GAP = 5,
  parameter int STAGE   = 0
) (
  input  logic               axi_clk,
  input  logic               aresetn,
  input  logic [PHV_LEN-1:0] phv_in,
  input  logic               phv_valid_in,
  output logic               ready_out,
  output logic [KEY_LEN-1:0] extract_key,
  output logic               key_valid,
  output logic               cond_flag,
  output logic [PHV_LEN-1:0] pkt_hdr_vec_out,
  input  logic [CFG_W-1:0]   cfg_din,
  input  logic [3:0]         cfg_addr,
  input  logic               cfg_en
`ifdef KEY_EXTRACTOR_MASK_EN
  ,
  input  logic [KEY_LEN-1:0] mask_din,
  input  logic [3:0]         mask_addr,
  input  logic               mask_en
`endif
);

  localparam int       c_C6_TOP   = 1023;
  localparam int       c_C4_TOP   = 639;
  localparam int       c_C2_TOP   = 383;
  localparam logic [3:0] c_GAP_LOAD = 4'(MIN_GAP - 1);

  // The container layout and config packing are fixed; reject other builds.
  if (PHV_LEN != 1024 || KEY_LEN != 192 || CFG_W != 39 ||
      MIN_GAP < 3 || MIN_GAP > 15 || STAGE < 0) begin : g_param_check
    $error("key_extractor: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ    = 2'd1,
    S_EXTRACT = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  state_t               r_state;
  logic [3:0]           r_gap_cnt;
  logic [PHV_LEN-1:0]   r_phv;
  logic [CFG_W-1:0]     r_cfg_mem [16];
  logic [CFG_W-1:0]     r_cfg_rd;

  logic                 w_xfer;
  logic [3:0]           w_vid;
  logic [47:0]          w_c6 [8];
  logic [31:0]          w_c4 [8];
  logic [15:0]          w_c2 [8];
  logic [KEY_LEN-1:0]   w_key;
  logic [KEY_LEN-1:0]   w_key_out;
  logic                 w_cond;
  logic [15:0]          w_operand;
  logic [15:0]          w_imm;

  assign w_xfer = phv_valid_in && ready_out;
  assign w_vid  = phv_in[255:252];

  // Config RAM: reads only on accept, so a same-cycle write is seen next packet.
  always_ff @(posedge axi_clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < 16; i++) r_cfg_mem[i] <= '0;
      r_cfg_rd <= '0;
    end else begin
      if (cfg_en) r_cfg_mem[cfg_addr] <= cfg_din;
      if (w_xfer) r_cfg_rd <= r_cfg_mem[w_vid];
    end
  end

`ifdef KEY_EXTRACTOR_MASK_EN
  logic [KEY_LEN-1:0] r_mask_mem [16];
  logic [KEY_LEN-1:0] r_mask_rd;

  always_ff @(posedge axi_clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < 16; i++) r_mask_mem[i] <= '1;
      r_mask_rd <= '1;
    end else begin
      if (mask_en) r_mask_mem[mask_addr] <= mask_din;
      if (w_xfer) r_mask_rd <= r_mask_mem[w_vid];
    end
  end

  assign w_key_out = w_key & r_mask_rd;
`else
  assign w_key_out = w_key;
`endif

  for (genvar gi = 0; gi < 8; gi++) begin : g_containers
    assign w_c6[gi] = r_phv[c_C6_TOP - 48*gi -: 48];
    assign w_c4[gi] = r_phv[c_C4_TOP - 32*gi -: 32];
    assign w_c2[gi] = r_phv[c_C2_TOP - 16*gi -: 16];
  end

  assign w_key = {w_c6[r_cfg_rd[38:36]], w_c6[r_cfg_rd[35:33]],
                  w_c4[r_cfg_rd[32:30]], w_c4[r_cfg_rd[29:27]],
                  w_c2[r_cfg_rd[26:24]], w_c2[r_cfg_rd[23:21]]};

  assign w_operand = w_c2[r_cfg_rd[20:18]];
  assign w_imm     = r_cfg_rd[15:0];

  always_comb begin
    w_cond = 1'b1;
    case (r_cfg_rd[17:16])
      2'b00:   w_cond = 1'b1;
      2'b01:   w_cond = (w_operand == w_imm);
      2'b10:   w_cond = (w_operand >  w_imm);
      default: w_cond = (w_operand <  w_imm);
    endcase
  end

  // Gap counter is loaded on accept and runs through READ/EXTRACT/GAP alike;
  // leaving at count 1 reopens ready_out exactly MIN_GAP cycles after accept.
  always_ff @(posedge axi_clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state         <= S_IDLE;
      r_gap_cnt       <= '0;
      r_phv           <= '0;
      ready_out       <= 1'b0;
      key_valid       <= 1'b0;
      cond_flag       <= 1'b0;
      extract_key     <= '0;
      pkt_hdr_vec_out <= '0;
    end else begin
      key_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_phv     <= phv_in;
            r_gap_cnt <= c_GAP_LOAD;
            ready_out <= 1'b0;
            r_state   <= S_READ;
          end else begin
            ready_out <= 1'b1;
          end
        end
        S_READ: begin
          r_gap_cnt       <= r_gap_cnt - 4'd1;
          extract_key     <= w_key_out;
          cond_flag       <= w_cond;
          pkt_hdr_vec_out <= r_phv;
          key_valid       <= 1'b1;
          r_state         <= S_EXTRACT;
        end
        S_EXTRACT, S_GAP: begin
          r_gap_cnt <= r_gap_cnt - 4'd1;
          if (r_gap_cnt == 4'd1) begin
            r_state   <= S_IDLE;
            ready_out <= 1'b1;
          end else begin
            r_state   <= S_GAP;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          ready_out <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_extractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_key_extractor                                                 |
// | Purpose : Self-checking bench for key_extractor (KEY_EXTRACTOR_MASK_EN     |
// |           adds the mask cases).                                            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_key_extractor;

  localparam int MIN_GAP = 5;

  logic          axi_clk = 1'b0;
  logic          aresetn;
  logic [1023:0] phv_in;
  logic          phv_valid_in;
  logic          ready_out;
  logic [191:0]  extract_key;
  logic          key_valid;
  logic          cond_flag;
  logic [1023:0] pkt_hdr_vec_out;
  logic [38:0]   cfg_din;
  logic [3:0]    cfg_addr;
  logic          cfg_en;
`ifdef KEY_EXTRACTOR_MASK_EN
  logic [191:0]  mask_din;
  logic [3:0]    mask_addr;
  logic          mask_en;
`endif

  key_extractor #(.MIN_GAP(MIN_GAP)) dut (
    .axi_clk         (axi_clk),
    .aresetn         (aresetn),
    .phv_in          (phv_in),
    .phv_valid_in    (phv_valid_in),
    .ready_out       (ready_out),
    .extract_key     (extract_key),
    .key_valid       (key_valid),
    .cond_flag       (cond_flag),
    .pkt_hdr_vec_out (pkt_hdr_vec_out),
    .cfg_din         (cfg_din),
    .cfg_addr        (cfg_addr),
    .cfg_en          (cfg_en)
`ifdef KEY_EXTRACTOR_MASK_EN
    ,
    .mask_din        (mask_din),
    .mask_addr       (mask_addr),
    .mask_en         (mask_en)
`endif
  );

  always #5 axi_clk = ~axi_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0]    vid;
    logic [38:0]   cfg;
    logic [1023:0] phv;
    logic          exp_cond;
    logic [191:0]  exp_key;
  } vec_t;

  typedef struct {
    int            at;
    logic [191:0]  key;
    logic          cond;
    logic [1023:0] phv;
  } exp_t;

  logic [38:0]  cfg_m  [16];
  logic [191:0] mask_m [16];

  task automatic step();
    @(posedge axi_clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_phv(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      for (int w = 31; w >= 0; w--) begin
        if (act[w*32 +: 32] !== exp[w*32 +: 32]) begin
          $display("FAIL %s: word %0d got %h expected %h", nm, w, act[w*32 +: 32], exp[w*32 +: 32]);
          break;
        end
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready_out !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("ready_timeout", 192'(ready_out), 192'd1);
  endtask

  task automatic write_cfg(input logic [3:0] a, input logic [38:0] d);
    cfg_en = 1'b1; cfg_addr = a; cfg_din = d;
    step();
    cfg_en = 1'b0;
    cfg_m[a] = d;
  endtask

  // Reference key/condition straight from the container layout.
  function automatic logic [191:0] ref_key(input logic [1023:0] p, input logic [38:0] c);
    int a0 = int'(c[38:36]); int a1 = int'(c[35:33]);
    int b0 = int'(c[32:30]); int b1 = int'(c[29:27]);
    int d0 = int'(c[26:24]); int d1 = int'(c[23:21]);
    return {p[1023-48*a0 -: 48], p[1023-48*a1 -: 48],
            p[639-32*b0 -: 32],  p[639-32*b1 -: 32],
            p[383-16*d0 -: 16],  p[383-16*d1 -: 16]};
  endfunction

  function automatic logic ref_cond(input logic [1023:0] p, input logic [38:0] c);
    logic [15:0] x;
    logic [15:0] imm;
    x   = p[383-16*int'(c[20:18]) -: 16];
    imm = c[15:0];
    case (c[17:16])
      2'd0:    return 1'b1;
      2'd1:    return x == imm;
      2'd2:    return x > imm;
      default: return x < imm;
    endcase
  endfunction

  function automatic logic [38:0] cfgw(input int a0, a1, b0, b1, d0, d1, ci, input logic [1:0] op,
                                       input logic [15:0] imm);
    return {3'(a0), 3'(a1), 3'(b0), 3'(b1), 3'(d0), 3'(d1), 3'(ci), op, imm};
  endfunction

  function automatic logic [47:0] v6(input int i, input logic [15:0] s);
    return {8'hC6, 8'(i), s, s};
  endfunction
  function automatic logic [31:0] v4(input int i, input logic [15:0] s);
    return {8'hC4, 8'(i), s};
  endfunction
  function automatic logic [15:0] v2(input int i, input logic [15:0] s, input logic [15:0] ov);
    return (i == 2) ? ov : {4'h2, 4'(i), s[7:0]};
  endfunction

  function automatic logic [1023:0] mk_phv(input logic [15:0] s, input logic [3:0] vid,
                                           input logic [15:0] ov);
    logic [1023:0] p;
    for (int i = 0; i < 8; i++) begin
      p[1023-48*i -: 48] = v6(i, s);
      p[639-32*i -: 32]  = v4(i, s);
      p[383-16*i -: 16]  = v2(i, s, ov);
    end
    p[255:252] = vid;
    p[251:0]   = {63{s[3:0]}};
    return p;
  endfunction

  function automatic vec_t mkvec(input logic [3:0] vid, input int a0, a1, b0, b1, d0, d1, ci,
                                 input logic [1:0] op, input logic [15:0] imm,
                                 input logic [15:0] ov, input logic ec, input logic [15:0] s);
    vec_t v;
    v.vid      = vid;
    v.cfg      = cfgw(a0, a1, b0, b1, d0, d1, ci, op, imm);
    v.phv      = mk_phv(s, vid, ov);
    v.exp_cond = ec;
    v.exp_key  = {v6(a0, s), v6(a1, s), v4(b0, s), v4(b1, s), v2(d0, s, ov), v2(d1, s, ov)};
    return v;
  endfunction

  function automatic logic [1023:0] rand_phv();
    logic [1023:0] p;
    for (int w = 0; w < 32; w++) p[w*32 +: 32] = $urandom;
    return p;
  endfunction

  // Issue one packet in the current (ready) cycle and check the pulse at t+2.
  task automatic send_check(input string nm, input logic [1023:0] p,
                            input logic [191:0] ek, input logic ec);
    wait_ready();
    phv_in = p; phv_valid_in = 1'b1;
    step();
    phv_valid_in = 1'b0;
    chk({nm, "_kv_t1"}, 192'(key_valid), 192'd0);
    step();
    chk({nm, "_kv_t2"}, 192'(key_valid), 192'd1);
    chk({nm, "_key"}, extract_key, ek);
    chk({nm, "_cond"}, 192'(cond_flag), 192'(ec));
    chk_phv({nm, "_phv"}, pkt_hdr_vec_out, p);
    step();
    chk({nm, "_kv_t3"}, 192'(key_valid), 192'd0);
  endtask

  vec_t tbl[8];
  exp_t q[$];

  initial begin
    logic [38:0]   cfg_a;
    logic [38:0]   cfg_b;
    logic [1023:0] p;
    int            next_ok;

    aresetn = 1'b0; phv_in = '0; phv_valid_in = 1'b0;
    cfg_din = '0; cfg_addr = '0; cfg_en = 1'b0;
`ifdef KEY_EXTRACTOR_MASK_EN
    mask_din = '0; mask_addr = '0; mask_en = 1'b0;
`endif
    for (int i = 0; i < 16; i++) begin cfg_m[i] = '0; mask_m[i] = '1; end

    tbl[0] = mkvec(4'd3,  1, 0, 2, 7, 5, 5, 0, 2'b00, 16'h0000, 16'h1111, 1'b1, 16'h1000);
    tbl[1] = mkvec(4'd3,  2, 3, 0, 1, 2, 3, 2, 2'b01, 16'h0800, 16'h0800, 1'b1, 16'h1001);
    tbl[2] = mkvec(4'd3,  2, 3, 0, 1, 2, 3, 2, 2'b01, 16'h0800, 16'h86DD, 1'b0, 16'h1002);
    tbl[3] = mkvec(4'd5,  7, 6, 5, 4, 3, 2, 2, 2'b10, 16'h0800, 16'h0801, 1'b1, 16'h1003);
    tbl[4] = mkvec(4'd5,  7, 6, 5, 4, 3, 2, 2, 2'b10, 16'h0801, 16'h0800, 1'b0, 16'h1004);
    tbl[5] = mkvec(4'd9,  4, 4, 1, 6, 7, 0, 2, 2'b11, 16'h0801, 16'h0800, 1'b1, 16'h1005);
    tbl[6] = mkvec(4'd9,  4, 4, 1, 6, 7, 0, 2, 2'b11, 16'h0800, 16'h0801, 1'b0, 16'h1006);
    tbl[7] = mkvec(4'd15, 0, 7, 3, 3, 6, 1, 2, 2'b01, 16'h1234, 16'h1234, 1'b1, 16'h1007);

    // Reset state
    repeat (3) step();
    chk("rst_ready", 192'(ready_out), 192'd0);
    chk("rst_kv", 192'(key_valid), 192'd0);
    chk("rst_key", extract_key, 192'd0);
    chk("rst_cond", 192'(cond_flag), 192'd0);
    chk_phv("rst_phv", pkt_hdr_vec_out, '0);
    aresetn = 1'b1;
    step();
    chk("rel_ready", 192'(ready_out), 192'd1);

    // Directed table
    for (int k = 0; k < 8; k++) begin
      write_cfg(tbl[k].vid, tbl[k].cfg);
      send_check($sformatf("vec%0d", k), tbl[k].phv, tbl[k].exp_key, tbl[k].exp_cond);
    end

    // Continuous valid: accepts every MIN_GAP cycles
    wait_ready();
    phv_in = tbl[0].phv; phv_valid_in = 1'b1;
    for (int k = 0; k < 13; k++) begin
      chk($sformatf("b2b_ready%0d", k), 192'(ready_out), 192'(k % MIN_GAP == 0));
      chk($sformatf("b2b_kv%0d", k), 192'(key_valid), 192'(k % MIN_GAP == 2));
      step();
    end
    phv_valid_in = 1'b0;

    // Config write in the transfer cycle: old entry applies to this packet
    cfg_a = cfgw(1, 2, 3, 4, 5, 6, 7, 2'b00, 16'h0);
    cfg_b = cfgw(6, 5, 4, 3, 2, 1, 0, 2'b01, 16'hFFFF);
    write_cfg(4'd3, cfg_a);
    wait_ready();
    p = mk_phv(16'h2222, 4'd3, 16'hABCD);
    phv_in = p; phv_valid_in = 1'b1;
    cfg_en = 1'b1; cfg_addr = 4'd3; cfg_din = cfg_b;
    step();
    phv_valid_in = 1'b0; cfg_en = 1'b0; cfg_m[3] = cfg_b;
    step();
    chk("rw_kv", 192'(key_valid), 192'd1);
    chk("rw_old_key", extract_key, ref_key(p, cfg_a));
    chk("rw_old_cond", 192'(cond_flag), 192'(ref_cond(p, cfg_a)));
    send_check("rw_new", p, ref_key(p, cfg_b), ref_cond(p, cfg_b));

    // Reset one cycle after a transfer drops the packet
    wait_ready();
    phv_in = p; phv_valid_in = 1'b1;
    step();
    phv_valid_in = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("mid_rst_ready", 192'(ready_out), 192'd0);
    chk("mid_rst_key", extract_key, 192'd0);
    chk("mid_rst_cond", 192'(cond_flag), 192'd0);
    chk_phv("mid_rst_phv", pkt_hdr_vec_out, '0);
    step();
    chk("mid_rst_kv_t2", 192'(key_valid), 192'd0);
    aresetn = 1'b1;
    for (int i = 0; i < 16; i++) begin cfg_m[i] = '0; mask_m[i] = '1; end
    step();
    chk("mid_rel_ready", 192'(ready_out), 192'd1);
    chk("mid_rel_kv", 192'(key_valid), 192'd0);
    send_check("post_rst", p, ref_key(p, '0), 1'b1);

    // Randomized traffic and config writes against the model
    wait_ready();
    for (int i = 0; i < 16; i++) write_cfg(4'(i), 39'({$urandom, $urandom}));
    next_ok = cyc;
    for (int i = 0; i < 606; i++) begin
      phv_valid_in = (i < 600) && ($urandom_range(0, 9) < 7);
      phv_in       = rand_phv();
      cfg_en       = ($urandom_range(0, 3) == 0);
      cfg_addr     = 4'($urandom);
      cfg_din      = 39'({$urandom, $urandom});
      chk("rnd_ready", 192'(ready_out), 192'(cyc >= next_ok));
      if (q.size() > 0 && q[0].at == cyc) begin
        chk("rnd_kv", 192'(key_valid), 192'd1);
        chk("rnd_key", extract_key, q[0].key);
        chk("rnd_cond", 192'(cond_flag), 192'(q[0].cond));
        chk_phv("rnd_phv", pkt_hdr_vec_out, q[0].phv);
        void'(q.pop_front());
      end else begin
        chk("rnd_kv", 192'(key_valid), 192'd0);
      end
      if (phv_valid_in && cyc >= next_ok) begin
        q.push_back('{cyc + 2,
                      ref_key(phv_in, cfg_m[phv_in[255:252]]) & mask_m[phv_in[255:252]],
                      ref_cond(phv_in, cfg_m[phv_in[255:252]]), phv_in});
        next_ok = cyc + MIN_GAP;
      end
      if (cfg_en) cfg_m[cfg_addr] = cfg_din;
      step();
    end
    cfg_en = 1'b0; phv_valid_in = 1'b0;
    chk("rnd_drained", 192'(q.size()), 192'd0);

`ifdef KEY_EXTRACTOR_MASK_EN
    // Mask VID 3 low 16 bits; VID 7 keeps its reset mask of all ones
    mask_en = 1'b1; mask_addr = 4'd3; mask_din = {{176{1'b1}}, 16'h0000};
    step();
    mask_en = 1'b0;
    p = mk_phv(16'h3333, 4'd3, 16'h5A5A);
    send_check("mask_v3", p, {ref_key(p, cfg_m[3])[191:16], 16'h0000}, ref_cond(p, cfg_m[3]));
    p = mk_phv(16'h4444, 4'd7, 16'hA5A5);
    send_check("mask_v7", p, ref_key(p, cfg_m[7]), ref_cond(p, cfg_m[7]));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
